// File: rtl/button_event_arbiter.sv
// Per-channel edge-detecting button event capture with a round-robin arbiter.
// Optional input debounce filter: define BUTTON_EVENT_ARBITER_DEBOUNCE_EN.
module button_event_arbiter #(
  parameter int N         = 4,
  parameter int DB_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         btn,
  output logic                 ev_valid,
  output logic [$clog2(N)-1:0] ev_id,
  input  logic                 ev_ready,
  output logic [N-1:0]         pend,
  output logic [N-1:0]         ovf
);

  localparam int W = $clog2(N);

  typedef enum logic [1:0] {
    D_IDLE,
    D_FIRE,
    D_HELD
  } det_e;

  typedef enum logic {
    ARB,
    OFFER
  } arb_e;

  if (N < 2 || N > 8 || DB_CYCLES < 1) begin : g_bad_param
    $error("button_event_arbiter: illegal N or DB_CYCLES");
  end

  logic [N-1:0] btn_f;

`ifdef BUTTON_EVENT_ARBITER_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] db_cnt_q [N];
  logic [CW-1:0] db_cnt_d [N];
  logic [N-1:0]  db_out_q;
  logic [N-1:0]  db_out_d;

  // Count consecutive samples that disagree with the filtered level.
  always_comb begin
    db_out_d = db_out_q;
    for (int k = 0; k < N; k++) begin
      db_cnt_d[k] = '0;
      if (btn[k] != db_out_q[k]) begin
        if (db_cnt_q[k] == CW'(DB_CYCLES - 1)) begin
          db_out_d[k] = btn[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_out_q <= '0;
      db_cnt_q <= '{default: '0};
    end else begin
      db_out_q <= db_out_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign btn_f = db_out_q;
`else
  assign btn_f = btn;
`endif

  det_e          det_q [N];
  det_e          det_d [N];
  logic [N-1:0]  evt;
  logic [N-1:0]  pend_q, pend_d;
  logic [N-1:0]  ovf_q, ovf_d;

  arb_e          st_q, st_d;
  logic          ev_valid_q, ev_valid_d;
  logic [W-1:0]  ev_id_q, ev_id_d;
  logic [W-1:0]  ptr_q, ptr_d;
  logic          hs;
  logic          found;
  logic [W-1:0]  sel;
  int            idx;

  assign hs = (st_q == OFFER) && ev_ready;

  // Detectors fire once per press; pending/overflow bookkeeping.
  always_comb begin
    evt    = '0;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    for (int k = 0; k < N; k++) begin
      det_d[k] = det_q[k];
      unique case (det_q[k])
        D_IDLE:  if (btn_f[k]) det_d[k] = D_FIRE;
        D_FIRE:  det_d[k] = D_HELD;
        D_HELD:  if (!btn_f[k]) det_d[k] = D_IDLE;
        default: det_d[k] = D_IDLE;
      endcase
      evt[k] = (det_q[k] == D_FIRE);
      if (hs && ev_id_q == W'(k)) begin
        pend_d[k] = 1'b0;
      end
      if (evt[k]) begin
        if (pend_q[k] && !(hs && ev_id_q == W'(k))) begin
          ovf_d[k] = 1'b1;
        end
        pend_d[k] = 1'b1;
      end
    end
  end

  // Detector and pending/overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      det_q  <= '{default: D_IDLE};
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      det_q  <= det_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  // Round-robin pick and offer/handshake sequencing.
  always_comb begin
    st_d       = st_q;
    ev_valid_d = ev_valid_q;
    ev_id_d    = ev_id_q;
    ptr_d      = ptr_q;
    found      = 1'b0;
    sel        = '0;
    idx        = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        sel   = W'(idx);
      end
    end
    unique case (st_q)
      ARB: begin
        if (found) begin
          ev_id_d    = sel;
          ev_valid_d = 1'b1;
          st_d       = OFFER;
        end
      end
      OFFER: begin
        if (ev_ready) begin
          ev_valid_d = 1'b0;
          ptr_d      = (ev_id_q == W'(N - 1)) ? '0 : ev_id_q + 1'b1;
          st_d       = ARB;
        end
      end
      default: st_d = ARB;
    endcase
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ARB;
      ev_valid_q <= 1'b0;
      ev_id_q    <= '0;
      ptr_q      <= '0;
    end else begin
      st_q       <= st_d;
      ev_valid_q <= ev_valid_d;
      ev_id_q    <= ev_id_d;
      ptr_q      <= ptr_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_id    = ev_id_q;
  assign pend     = pend_q;
  assign ovf      = ovf_q;

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requester channels (legal 2..8).
REQ-002 SHALL have parameter DB_CYCLES, default 16, meaning debounce stable-sample count, used only under BUTTON_EVENT_ARBITER_DEBOUNCE_EN.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port btn, input, N, meaning long-pulse requests, already synchronous to clk.
REQ-006 SHALL have port ev_valid, output, 1, meaning event offered.
REQ-007 SHALL have port ev_id, output, clog2(N), meaning index of the offered channel.
REQ-008 SHALL have port ev_ready, input, 1, meaning the consumer accepts the event.
REQ-009 SHALL have port pend, output, N, meaning per-channel pending flags.
REQ-010 SHALL have port ovf, output, N, meaning sticky per-channel dropped-event flags.

Function
REQ-011 SHALL give each channel a 3-state detector: IDLE -> FIRE when btn[k] is sampled high; FIRE -> HELD unconditionally; HELD -> IDLE when btn[k] is sampled low, else stay HELD.
REQ-012 SHALL raise a one-cycle event[k] in FIRE only, so a channel re-arms only after btn[k] is sampled low at least once.
REQ-013 SHALL set pend[k] on the edge ending a cycle with event[k]=1.
REQ-014 SHALL set ovf[k] and drop the event when event[k]=1, pend[k]=1, and pend[k] is not being cleared that edge.
REQ-015 SHALL keep pend[k] set with no ovf when event[k] coincides with the handshake clearing pend[k], so the new event wins.
REQ-016 SHALL use an arbiter FSM with states ARB and OFFER.
REQ-017 In ARB with any pend bit set, SHALL select the first set bit searching from pointer ptr upward modulo N, load ev_id, assert ev_valid and enter OFFER on the next edge.
REQ-018 In OFFER, ev_valid and ev_id SHALL hold stable until ev_valid&&ev_ready is sampled.
REQ-019 On handshake, SHALL clear pend[ev_id], set ptr=(ev_id+1) mod N, deassert ev_valid and return to ARB on that edge.
REQ-020 Throughput SHALL be at most one event per 2 cycles, since ARB always takes one cycle.
REQ-021 With no debounce and an idle arbiter, ev_valid SHALL rise 3 edges after the first edge sampling btn[k] high: edge t detector FIRE, t+1 pend set, t+2 ev_valid.
REQ-022 ev_ready SHALL be ignored while ev_valid=0.
REQ-023 pend SHALL be a direct register output.

Reset
REQ-024 While rst=1 at an edge: ev_valid=0, ev_id=0, pend=0, ovf=0, ptr=0, arbiter in ARB, all detectors in IDLE.
REQ-025 Reset SHALL take priority over all other activity, including a handshake in the same cycle, which is then not counted.
REQ-026 A btn held high across reset release SHALL produce exactly one event.
REQ-027 ovf SHALL be cleared only by reset.

Configuration
REQ-028 With BUTTON_EVENT_ARBITER_DEBOUNCE_EN defined, each btn[k] SHALL pass a filter whose output changes only after DB_CYCLES consecutive equal samples differing from the current output (filter resets to 0), adding DB_CYCLES edges of latency.
REQ-029 Without BUTTON_EVENT_ARBITER_DEBOUNCE_EN, btn[k] SHALL feed the detector directly, no filter logic SHALL exist, and DB_CYCLES is unused.

Verification
REQ-030 Case 1: N=4, ev_ready=1, btn[2] high for 10 cycles -> exactly one handshake with ev_id=2, ev_valid rising 3 edges after first high sample, and ovf=0.
REQ-031 Case 2: btn[0..3] rise on the same edge, ev_ready=1 -> ev_id sequence 0,1,2,3 with ev_valid high every other cycle.
REQ-032 Case 3: ptr=2 after a grant of 1, then btn[0] and btn[3] pending together -> ev_id 3 is granted first, then 0.
REQ-033 Case 4: ev_ready=0, btn[1] pulsed twice with a low gap -> ev_valid/ev_id=1 held stable, pend[1]=1, ovf[1]=1, one handshake after ev_ready rises.
REQ-034 Case 5: rst asserted during OFFER with ev_ready=1 -> next cycle ev_valid=0, pend=0, ovf=0, no handshake counted.
REQ-035 Case 6 (DEBOUNCE_EN, DB_CYCLES=4): btn[0] toggles every cycle for 20 cycles then stays high -> exactly one event, ev_valid rising 4+3 edges after the stable-high start.
